// File: rtl/geofence_sqrt_arbiter_if.sv
// Request/grant/result bundle between the GeoFence stages and the shared square-root engine.
interface geofence_sqrt_arbiter_if #(
  parameter int unsigned NREQ  = 4,
  parameter int unsigned OUT_W = 10
);
  logic [NREQ-1:0]           req;
  logic [NREQ*2*OUT_W-1:0]   radicand;
  logic [NREQ-1:0]           gnt;
  logic                      busy;
  logic [NREQ-1:0]           done;
  logic [OUT_W-1:0]          root;

  modport master (output req, radicand, input gnt, busy, done, root);
  modport slave  (input req, radicand, output gnt, busy, done, root);
endinterface

// File: rtl/geofence_sqrt_arbiter.sv
// Shared bit-serial floor(sqrt) engine with round-robin arbitration across NREQ requesters.
module geofence_sqrt_arbiter #(
  parameter int unsigned NREQ  = 4,
  parameter int unsigned OUT_W = 10
) (
  input  logic                   clk,
  input  logic                   reset_n,
  geofence_sqrt_arbiter_if.slave bus
);
  localparam int unsigned RAD_W = 2 * OUT_W;
  localparam int unsigned IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int unsigned CNT_W = $clog2(OUT_W);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t            state_q, state_d;
  logic [IDX_W-1:0]  ptr_q, ptr_d, idx_q, idx_d;
  logic [RAD_W-1:0]  work_q, work_d;
  logic [OUT_W+1:0]  rem_q, rem_d;
  logic [OUT_W-1:0]  acc_q, acc_d, root_q, root_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [NREQ-1:0]   gnt_q, gnt_d, done_q, done_d;

  logic              found;
  logic [IDX_W-1:0]  sel;
  int unsigned       scan;
  logic [RAD_W-1:0]  rad_sel;
  logic [NREQ-1:0]   oh_sel, oh_idx;
  logic [OUT_W+1:0]  rem_sh, trial;
  logic              ge;

  // Rotating priority scan starting at ptr_q
  always_comb begin
    found = 1'b0;
    sel   = '0;
    scan  = 0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      scan = 32'(ptr_q) + i;
      if (scan >= NREQ) scan = scan - NREQ;
      if (!found && bus.req[IDX_W'(scan)]) begin
        found = 1'b1;
        sel   = IDX_W'(scan);
      end
    end
  end

  always_comb begin
    rad_sel = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (IDX_W'(i) == sel) rad_sel = bus.radicand[i*RAD_W +: RAD_W];
    end
    oh_sel      = '0;
    oh_sel[sel] = 1'b1;
    oh_idx        = '0;
    oh_idx[idx_q] = 1'b1;
  end

  // One restoring iteration: bring down two radicand bits, try subtracting 4*acc+1
  always_comb begin
    rem_sh = {rem_q[OUT_W-1:0], work_q[RAD_W-1 -: 2]};
    trial  = {acc_q, 2'b01};
    ge     = (rem_sh >= trial);
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    idx_d   = idx_q;
    work_d  = work_q;
    rem_d   = rem_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    root_d  = root_q;
    gnt_d   = '0;
    done_d  = '0;
    unique case (state_q)
      IDLE: begin
        if (found) begin
          work_d  = rad_sel;
          idx_d   = sel;
          rem_d   = '0;
          acc_d   = '0;
          cnt_d   = '0;
          gnt_d   = oh_sel;
          ptr_d   = (32'(sel) == NREQ - 1) ? '0 : sel + IDX_W'(1);
          state_d = CALC;
        end
      end
      CALC: begin
        rem_d  = ge ? (rem_sh - trial) : rem_sh;
        acc_d  = {acc_q[OUT_W-2:0], ge};
        work_d = work_q << 2;
        cnt_d  = cnt_q + CNT_W'(1);
        // Root and done are registered on the last iteration so they appear in the DONE cycle
        if (cnt_q == CNT_W'(OUT_W - 1)) begin
          root_d  = acc_d;
          done_d  = oh_idx;
          state_d = DONE;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      idx_q   <= '0;
      work_q  <= '0;
      rem_q   <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      root_q  <= '0;
      gnt_q   <= '0;
      done_q  <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      idx_q   <= idx_d;
      work_q  <= work_d;
      rem_q   <= rem_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      root_q  <= root_d;
      gnt_q   <= gnt_d;
      done_q  <= done_d;
    end
  end

  assign bus.gnt  = gnt_q;
  assign bus.done = done_q;
  assign bus.root = root_q;
  assign bus.busy = (state_q != IDLE);
endmodule

// File: tb/tb_geofence_sqrt_arbiter.sv
// Directed bench for geofence_sqrt_arbiter: vector table plus arbitration/reset corner sequences.
module tb_geofence_sqrt_arbiter;
  localparam int unsigned NREQ  = 4;
  localparam int unsigned OUT_W = 10;
  localparam int unsigned RAD_W = 2 * OUT_W;

  logic clk;
  logic reset_n;
  int   n_checks;
  int   n_fail;

  geofence_sqrt_arbiter_if #(.NREQ(NREQ), .OUT_W(OUT_W)) bus ();

  geofence_sqrt_arbiter #(.NREQ(NREQ), .OUT_W(OUT_W)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int unsigned      who;
    logic [RAD_W-1:0] rad;
    logic [OUT_W-1:0] exp_root;
  } vec_t;

  vec_t vecs [8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset_n      = 1'b0;
    bus.req      = '0;
    bus.radicand = '0;
    tick();
    tick();
    reset_n = 1'b1;
    tick();
  endtask

  // Single job from an idle block: gnt one edge after sampling, done ten edges later
  task automatic run_job(input int unsigned who, input logic [RAD_W-1:0] rad, input logic [OUT_W-1:0] exp_root);
    int lat;
    bus.radicand[who*RAD_W +: RAD_W] = rad;
    bus.req[who] = 1'b1;
    tick();
    chk("job_gnt", 32'(bus.gnt), 32'(1) << who);
    chk("job_busy", 32'(bus.busy), 1);
    bus.req[who] = 1'b0;
    lat = 0;
    for (int c = 0; c < 20; c++) begin
      tick();
      lat++;
      if (bus.done != '0) break;
    end
    chk("job_latency", lat, 10);
    chk("job_done", 32'(bus.done), 32'(1) << who);
    chk("job_root", 32'(bus.root), 32'(exp_root));
    tick();
    chk("job_idle_busy", 32'(bus.busy), 0);
    chk("job_root_hold", 32'(bus.root), 32'(exp_root));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int          ng, nd, lat, busy_cnt, busy_after, g3, ndone;
    logic [3:0]  gv [4];
    int          gc [4];
    logic [3:0]  dv [4];
    logic [9:0]  rv [4];
    logic [3:0]  ro_done;
    logic [9:0]  ro_root;
    bit          seen_done;

    n_checks = 0;
    n_fail   = 0;
    vecs[0] = '{0, 20'd0,       10'd0};
    vecs[1] = '{1, 20'd1048575, 10'd1023};
    vecs[2] = '{1, 20'd522729,  10'd723};
    vecs[3] = '{1, 20'd522728,  10'd722};
    vecs[4] = '{1, 20'd1000,    10'd31};
    vecs[5] = '{1, 20'd1,       10'd1};
    vecs[6] = '{3, 20'd999999,  10'd999};
    vecs[7] = '{2, 20'd4,       10'd2};

    reset_n      = 1'b0;
    bus.req      = '0;
    bus.radicand = '0;
    #3;
    chk("reset_gnt",  32'(bus.gnt),  0);
    chk("reset_done", 32'(bus.done), 0);
    chk("reset_busy", 32'(bus.busy), 0);
    chk("reset_root", 32'(bus.root), 0);
    do_reset();

    for (int i = 0; i < 8; i++) run_job(vecs[i].who, vecs[i].rad, vecs[i].exp_root);

    // All four requesting after reset: served 0,1,2,3 every 12 cycles
    do_reset();
    ng = 0; nd = 0;
    for (int i = 0; i < 4; i++) begin gv[i] = '0; gc[i] = 0; dv[i] = '0; rv[i] = '0; end
    bus.radicand = {20'd25, 20'd16, 20'd9, 20'd4};
    bus.req      = 4'hF;
    for (int c = 1; c <= 70 && nd < 4; c++) begin
      tick();
      if (bus.gnt != '0 && ng < 4) begin
        gv[ng] = bus.gnt; gc[ng] = c; ng++;
        bus.req = bus.req & ~bus.gnt;
      end
      if (bus.done != '0 && nd < 4) begin
        dv[nd] = bus.done; rv[nd] = bus.root; nd++;
      end
    end
    chk("rr_grant_count", ng, 4);
    chk("rr_done_count", nd, 4);
    for (int i = 0; i < 4; i++) begin
      chk("rr_gnt", 32'(gv[i]), 32'(1) << i);
      chk("rr_done", 32'(dv[i]), 32'(1) << i);
      chk("rr_root", 32'(rv[i]), i + 2);
      if (i > 0) chk("rr_spacing", gc[i] - gc[i-1], 12);
    end
    tick();

    // Requesters 0 and 2 held continuously alternate
    do_reset();
    ng = 0;
    for (int i = 0; i < 4; i++) gv[i] = '0;
    bus.radicand = {20'd0, 20'd49, 20'd0, 20'd100};
    bus.req      = 4'b0101;
    for (int c = 0; c < 80 && ng < 4; c++) begin
      tick();
      if (bus.gnt != '0) begin gv[ng] = bus.gnt; ng++; end
    end
    bus.req = '0;
    chk("alt_grant_count", ng, 4);
    chk("alt_gnt0", 32'(gv[0]), 1);
    chk("alt_gnt1", 32'(gv[1]), 4);
    chk("alt_gnt2", 32'(gv[2]), 1);
    chk("alt_gnt3", 32'(gv[3]), 4);
    seen_done = 0;
    for (int c = 0; c < 20 && !seen_done; c++) begin
      tick();
      if (bus.done != '0) begin seen_done = 1; ro_done = bus.done; ro_root = bus.root; end
    end
    chk("alt_final_seen", 32'(seen_done), 1);
    chk("alt_final_done", 32'(ro_done), 4);
    chk("alt_final_root", 32'(ro_root), 7);
    tick();

    // Reset mid-job at the 5th CALC cycle; ptr here is 3 from the last grant
    bus.radicand[1*RAD_W +: RAD_W] = 20'd1000;
    bus.req[1] = 1'b1;
    tick();
    chk("mid_gnt", 32'(bus.gnt), 2);
    bus.req = '0;
    for (int c = 0; c < 4; c++) tick();
    chk("mid_busy_before", 32'(bus.busy), 1);
    reset_n = 1'b0;
    #1;
    chk("mid_rst_gnt",  32'(bus.gnt),  0);
    chk("mid_rst_done", 32'(bus.done), 0);
    chk("mid_rst_busy", 32'(bus.busy), 0);
    chk("mid_rst_root", 32'(bus.root), 0);
    tick();
    tick();
    reset_n = 1'b1;
    ndone = 0; busy_cnt = 0;
    for (int c = 0; c < 15; c++) begin
      tick();
      if (bus.done != '0) ndone++;
      if (bus.busy) busy_cnt++;
    end
    chk("mid_no_done", ndone, 0);
    chk("mid_no_busy", busy_cnt, 0);
    bus.radicand[1*RAD_W +: RAD_W] = 20'd522729;
    bus.radicand[3*RAD_W +: RAD_W] = 20'd16;
    bus.req = 4'b1010;
    tick();
    chk("post_rst_gnt", 32'(bus.gnt), 2);
    bus.req = '0;
    lat = 0;
    for (int c = 0; c < 20; c++) begin
      tick();
      lat++;
      if (bus.done != '0) break;
    end
    chk("post_rst_latency", lat, 10);
    chk("post_rst_done", 32'(bus.done), 2);
    chk("post_rst_root", 32'(bus.root), 723);
    tick();

    // req[3] raised and withdrawn during CALC is never served; busy covers CALC+DONE only
    bus.radicand[0*RAD_W +: RAD_W] = 20'd400;
    bus.radicand[3*RAD_W +: RAD_W] = 20'd25;
    bus.req[0] = 1'b1;
    tick();
    chk("wd_gnt", 32'(bus.gnt), 1);
    bus.req[0] = 1'b0;
    busy_cnt = 1; busy_after = 0; g3 = 0; ndone = 0; seen_done = 0;
    ro_done = '0; ro_root = '0;
    for (int c = 0; c < 30; c++) begin
      if (c == 0) bus.req[3] = 1'b1;
      if (c == 3) bus.req[3] = 1'b0;
      tick();
      if (bus.gnt[3]) g3++;
      if (seen_done && bus.busy) busy_after++;
      if (bus.busy) busy_cnt++;
      if (bus.done != '0) begin
        ndone++; seen_done = 1; ro_done = bus.done; ro_root = bus.root;
        chk("wd_busy_at_done", 32'(bus.busy), 1);
      end
    end
    chk("wd_no_gnt3", g3, 0);
    chk("wd_done_count", ndone, 1);
    chk("wd_done", 32'(ro_done), 1);
    chk("wd_root", 32'(ro_root), 20);
    chk("wd_busy_cycles", busy_cnt, 11);
    chk("wd_busy_after_done", busy_after, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
